// File: rtl/up_counter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// up_counter_ctrl_pkg
// Shared definitions for the up-counter sequencing controller.
//   state_t : 2-bit controller state
//   IDLE / RUN / PAUSE / DONE : fixed state encodings
// ---------------------------------------------------------------------------
package up_counter_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t PAUSE = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage : up_counter_ctrl_pkg

// File: rtl/up_counter_ctrl.sv
// ---------------------------------------------------------------------------
// up_counter_ctrl
// Sequencing controller for an N-bit up-counter. It counts from 0 up to a
// latched terminal value, either once (one-shot, ends in DONE) or repeatedly
// (periodic, reloads to 0). It emits a one-cycle terminal-count pulse.
//
// Ports:
//   clk           : system clock, rising edge active
//   reset         : asynchronous active-high reset
//   start         : start from IDLE/DONE, or resume from PAUSE
//   stop          : pause while running
//   clear         : abort to IDLE and zero the count (highest priority)
//   mode_periodic : 1 = periodic, 0 = one-shot (latched with start)
//   term_val      : terminal value (latched with start)
//   count         : current count (registered)
//   busy          : high in RUN or PAUSE (registered)
//   tc_pulse      : one-cycle terminal-count pulse (registered)
//   done          : high in DONE (registered)
// ---------------------------------------------------------------------------
module up_counter_ctrl
  import up_counter_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         mode_periodic,
  input  logic [N-1:0] term_val,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         tc_pulse,
  output logic         done
);

  localparam logic [N-1:0] ZERO   = {N{1'b0}};
  localparam logic [N-1:0] ONE    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ALL_1S = {N{1'b1}};

  state_t       r_state;
  logic [N-1:0] r_count;
  logic [N-1:0] r_term;
  logic         r_mode;
  logic         r_tc;
  logic         r_busy;
  logic         r_done;

  state_t       w_state_nxt;
  logic [N-1:0] w_count_nxt;
  logic [N-1:0] w_term_nxt;
  logic         w_mode_nxt;
  logic         w_tc_nxt;
  logic         w_busy_nxt;
  logic         w_done_nxt;
  logic         w_at_term;
  logic         w_start_only;

  assign w_at_term    = (r_count == r_term);
  // stop outranks start even in states where stop itself has no effect
  assign w_start_only = start & ~stop;

  // Next-state, count and terminal-register logic with clear > stop > start
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_term_nxt  = r_term;
    w_mode_nxt  = r_mode;
    w_tc_nxt    = 1'b0;
    if (clear) begin
      w_state_nxt = IDLE;
      w_count_nxt = ZERO;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_only) begin
            w_term_nxt  = term_val;
            w_mode_nxt  = mode_periodic;
            w_count_nxt = ZERO;
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = r_state;
          end
        end
        RUN: begin
          if (stop) begin
            // pausing suppresses the terminal pulse even at the terminal count
            w_state_nxt = PAUSE;
          end else if (w_at_term) begin
            w_tc_nxt = 1'b1;
            if (r_mode) begin
              w_count_nxt = ZERO;
            end else begin
              w_state_nxt = DONE;
            end
          end else begin
            w_count_nxt = r_count + ONE;
          end
        end
        PAUSE: begin
          if (w_start_only) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = PAUSE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = ZERO;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
    w_done_nxt = (w_state_nxt == DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= ZERO;
      r_term  <= ALL_1S;
      r_mode  <= 1'b0;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_term  <= w_term_nxt;
      r_mode  <= w_mode_nxt;
      r_tc    <= w_tc_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign count    = r_count;
  assign busy     = r_busy;
  assign tc_pulse = r_tc;
  assign done     = r_done;

endmodule : up_counter_ctrl
